// File: rtl/audio_dac_serializer.sv
// I2S transmit serializer: divides state_clk into BCLK/LRCK and shifts double-buffered L/R samples onto DACDAT.
// Define LEFT_JUSTIFIED_EN to switch the serial format from I2S to left-justified.
module audio_dac_serializer #(
    parameter int BCLK_DIV = 4,
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32
) (
    input  logic              state_clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] left_in_i,
    input  logic [DATA_W-1:0] right_in_i,
    output logic              bclk_o,
    output logic              lrck_o,
    output logic              dacdat_o,
    output logic              frame_start_o,
    output logic              underrun_o,
    output logic              busy_o
);

    // state | meaning
    // IDLE  | link stopped, serial outputs and counters held at 0
    // RUN   | frames stream continuously
    // DRAIN | enable dropped; finish the current frame, then stop
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int POS_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_TC = POS_W'(SLOT_W - 1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              right_q, right_d;
    logic              bclk_q, bclk_d;
    logic              lrck_q, lrck_d;
    logic              dacdat_q, dacdat_d;
    logic              fs_q, fs_d;
    logic              ur_q, ur_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] act_l_q, act_l_d;
    logic [DATA_W-1:0] act_r_q, act_r_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              fall_evt;
    logic              go_idle;
    logic [DATA_W-1:0] word;

    always_ff @(posedge state_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            pos_q        <= '0;
            right_q      <= 1'b0;
            bclk_q       <= 1'b0;
            lrck_q       <= 1'b0;
            dacdat_q     <= 1'b0;
            fs_q         <= 1'b0;
            ur_q         <= 1'b0;
            busy_q       <= 1'b0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            hold_valid_q <= 1'b0;
            act_l_q      <= '0;
            act_r_q      <= '0;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            pos_q        <= pos_d;
            right_q      <= right_d;
            bclk_q       <= bclk_d;
            lrck_q       <= lrck_d;
            dacdat_q     <= dacdat_d;
            fs_q         <= fs_d;
            ur_q         <= ur_d;
            busy_q       <= busy_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            hold_valid_q <= hold_valid_d;
            act_l_q      <= act_l_d;
            act_r_q      <= act_r_d;
            shift_q      <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        pos_d        = pos_q;
        right_d      = right_q;
        bclk_d       = bclk_q;
        lrck_d       = lrck_q;
        dacdat_d     = dacdat_q;
        fs_d         = 1'b0;
        ur_d         = 1'b0;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        hold_valid_d = hold_valid_q;
        act_l_d      = act_l_q;
        act_r_d      = act_r_q;
        shift_d      = shift_q;
        fall_evt     = 1'b0;
        go_idle      = 1'b0;
        word         = '0;

        // Leaving IDLE counts as a BCLK falling edge at bit 0 so the first frame starts at once.
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d  = RUN;
                    fall_evt = 1'b1;
                end
            end
            RUN: begin
                if (!enable_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable_i) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (div_q == DIV_TC) begin
                div_d  = '0;
                bclk_d = ~bclk_q;
                if (bclk_q) begin
                    if (state_q == DRAIN && !enable_i && pos_q == '0 && !right_q) go_idle = 1'b1;
                    else fall_evt = 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        if (load_i) begin
            hold_l_d     = left_in_i;
            hold_r_d     = right_in_i;
            hold_valid_d = 1'b1;
        end

        if (fall_evt) begin
            // Transfer samples the pre-load hold state; a coincident load survives for the next frame.
            if (pos_q == '0 && !right_q) begin
                fs_d = 1'b1;
                if (hold_valid_q) begin
                    act_l_d = hold_l_q;
                    act_r_d = hold_r_q;
                end else begin
                    ur_d = 1'b1;
                end
                hold_valid_d = load_i;
            end
            word = right_q ? act_r_q : act_l_d;
`ifdef LEFT_JUSTIFIED_EN
            lrck_d = ~right_q;
            if (pos_q == '0) begin
                dacdat_d = word[DATA_W-1];
                shift_d  = {word[DATA_W-2:0], 1'b0};
            end else begin
                dacdat_d = shift_q[DATA_W-1];
                shift_d  = {shift_q[DATA_W-2:0], 1'b0};
            end
`else
            // Slot bit 0 carries the I2S one-bit delay; the emptied shifter pads the slot tail with 0.
            lrck_d = right_q;
            if (pos_q == '0) begin
                dacdat_d = 1'b0;
                shift_d  = word;
            end else begin
                dacdat_d = shift_q[DATA_W-1];
                shift_d  = {shift_q[DATA_W-2:0], 1'b0};
            end
`endif
            if (pos_q == POS_TC) begin
                pos_d   = '0;
                right_d = ~right_q;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end

        if (go_idle) begin
            state_d  = IDLE;
            div_d    = '0;
            bclk_d   = 1'b0;
            lrck_d   = 1'b0;
            dacdat_d = 1'b0;
            pos_d    = '0;
            right_d  = 1'b0;
            shift_d  = '0;
        end

        busy_d = (state_d != IDLE);
    end

    assign bclk_o        = bclk_q;
    assign lrck_o        = lrck_q;
    assign dacdat_o      = dacdat_q;
    assign frame_start_o = fs_q;
    assign underrun_o    = ur_q;
    assign busy_o        = busy_q;

endmodule
